spare_alloc_scan_analyzer: RTL

Sequential, parametrised successor to the combinational spare-allocation check. Given pivot faults and a per-pivot row/column spare assignment, it first validates spare budgets, then latches the spare addresses. It then scans the non-pivot CAM LANES entries per cycle to flag covered faults, count uncovered faults and capture the first uncovered address. It sits between the fault-collection CAMs and the repair-solution search FSM, which issues one start per candidate assignment.

---
 rtl/spare_alloc_pkg.sv | 46 ++++
 rtl/np_cover_lane.sv | 32 +++
 rtl/spare_alloc_scan_analyzer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spare_alloc_pkg.sv
// Shared types and helpers for the spare-allocation scan analyser.
package spare_alloc_pkg;

   // Entry field widths; the analyser's ROW_W/COL_W follow these.
   localparam int FAULT_ROW_W = 10;
   localparam int FAULT_COL_W = 10;

   // Widest vector the popcount helper accepts (zero-extend narrower ones).
   localparam int POPCNT_W = 64;

   typedef enum logic [1:0] {
      ST_ALL_COVERED   = 2'd0,
      ST_UNCOVERED     = 2'd1,
      ST_PIVOT_OVERUSE = 2'd2,
      ST_UNC_LIMIT     = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_SCAN  = 2'd2,
      S_DONE  = 2'd3
   } fsm_e;

   // Pivot CAM entry as packed on the bus: {en,row,col}.
   typedef struct packed {
      logic                   en;
      logic [FAULT_ROW_W-1:0] row;
      logic [FAULT_COL_W-1:0] col;
   } pivot_entry_t;

   // Non-pivot CAM entry, same layout as a pivot entry.
   typedef struct packed {
      logic                   en;
      logic [FAULT_ROW_W-1:0] row;
      logic [FAULT_COL_W-1:0] col;
   } nonpivot_entry_t;

   function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POPCNT_W; i++) n = n + 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/np_cover_lane.sv
// One scan lane: decides whether a single non-pivot fault is covered by any
// of the spare rows/columns already assigned to pivots.
module np_cover_lane #(
   parameter int ROW_W = 10,
   parameter int COL_W = 10,
   parameter int PCAM  = 4
) (
   input  logic                       i_en,
   input  logic [ROW_W-1:0]           i_row,
   input  logic [COL_W-1:0]           i_col,
   input  logic [PCAM-1:0][ROW_W-1:0] i_sp_row,
   input  logic [PCAM-1:0]            i_sp_row_vld,
   input  logic [PCAM-1:0][COL_W-1:0] i_sp_col,
   input  logic [PCAM-1:0]            i_sp_col_vld,
   output logic                       o_covered
);

   logic w_row_hit;
   logic w_col_hit;

   // Disabled entries count as covered so they never add to the uncovered tally.
   always_comb begin
      w_row_hit = 1'b0;
      w_col_hit = 1'b0;
      for (int k = 0; k < PCAM; k++) begin
         if (i_sp_row_vld[k] && (i_sp_row[k] == i_row)) w_row_hit = 1'b1;
         if (i_sp_col_vld[k] && (i_sp_col[k] == i_col)) w_col_hit = 1'b1;
      end
      o_covered = !i_en || w_row_hit || w_col_hit;
   end

endmodule

// File: rtl/spare_alloc_scan_analyzer.sv
// Sequential spare-allocation check: validates pivot spare budgets, then scans
// the non-pivot CAM LANES entries per cycle, flagging covered faults, counting
// uncovered ones and capturing the lowest-index uncovered address.
module spare_alloc_scan_analyzer
   import spare_alloc_pkg::*;
#(
   parameter int ROW_W   = FAULT_ROW_W,
   parameter int COL_W   = FAULT_COL_W,
   parameter int PCAM    = 4,
   parameter int NPCAM   = 30,
   parameter int NUM_RS  = 2,
   parameter int NUM_CS  = 2,
   parameter int LANES   = 4,
   parameter int UNC_MAX = 8,
   localparam int E_W    = 1 + ROW_W + COL_W,
   localparam int RL_W   = $clog2(NUM_RS + 1),
   localparam int CL_W   = $clog2(NUM_CS + 1),
   localparam int CNT_W  = $clog2(NPCAM + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [PCAM*E_W-1:0]      i_pivot_fault_addr,
   input  logic [NPCAM*E_W-1:0]     i_nonpivot_fault_addr,
   input  logic [PCAM-1:0]          i_dsss,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [1:0]               o_status,
   output logic [RL_W-1:0]          o_rows_left,
   output logic [CL_W-1:0]          o_cols_left,
   output logic [CNT_W-1:0]         o_uncover_cnt,
   output logic [NPCAM-1:0]         o_nonpivot_cover_result,
   output logic                     o_first_uncover_vld,
   output logic [ROW_W+COL_W-1:0]   o_first_uncover_addr
);

   localparam int SEL_W = (NPCAM > 1) ? $clog2(NPCAM) : 1;
   localparam int IDX_W = $clog2(NPCAM + LANES + 1);

   fsm_e                       r_state;
   fsm_e                       w_state_nxt;

   logic [PCAM-1:0]            r_piv_en;
   logic [PCAM-1:0]            r_dsss;
   logic [PCAM-1:0][ROW_W-1:0] r_piv_row;
   logic [PCAM-1:0][COL_W-1:0] r_piv_col;
   logic [PCAM-1:0]            r_sp_row_vld;
   logic [PCAM-1:0]            r_sp_col_vld;
   logic [IDX_W-1:0]           r_idx;
   status_e                    r_status;
   logic [RL_W-1:0]            r_rows_left;
   logic [CL_W-1:0]            r_cols_left;
   logic [CNT_W-1:0]           r_unc_cnt;
   logic [NPCAM-1:0]           r_cover;
   logic                       r_first_vld;
   logic [ROW_W+COL_W-1:0]     r_first_addr;

   pivot_entry_t               w_piv_ent  [PCAM];
   nonpivot_entry_t            w_lane_ent [LANES];
   logic [LANES-1:0]           w_lane_act;
   logic [SEL_W-1:0]           w_lane_sel [LANES];
   logic [LANES-1:0]           w_lane_cov;

   int unsigned                w_rows_used;
   int unsigned                w_cols_used;
   logic                       w_overuse;
   logic [CNT_W-1:0]           w_unc_add;
   logic [CNT_W-1:0]           w_cnt_next;
   logic                       w_first_hit;
   logic [ROW_W+COL_W-1:0]     w_first_addr;
   logic                       w_limit;
   logic                       w_last;

   logic                       w_accept;
   logic                       w_latch_ok;
   logic                       w_latch_fail;
   logic                       w_scan_upd;

   // Split the flat pivot bus into entries.
   always_comb begin
      for (int k = 0; k < PCAM; k++) begin
         w_piv_ent[k] = i_pivot_fault_addr[k*E_W +: E_W];
      end
   end

   // Spare consumption by enabled pivots: dsss=1 takes a row, dsss=0 a column.
   always_comb begin
      w_rows_used = popcount(POPCNT_W'(r_piv_en & r_dsss));
      w_cols_used = popcount(POPCNT_W'(r_piv_en & ~r_dsss));
      w_overuse   = (int'(w_rows_used) > NUM_RS) || (int'(w_cols_used) > NUM_CS);
   end

   // Lane entry selection; lanes past the end of the CAM stay inactive.
   always_comb begin
      logic [IDX_W-1:0] v_idx;
      for (int l = 0; l < LANES; l++) begin
         v_idx         = r_idx + IDX_W'(l);
         w_lane_act[l] = (r_state == S_SCAN) && (v_idx < IDX_W'(NPCAM));
         w_lane_sel[l] = w_lane_act[l] ? v_idx[SEL_W-1:0] : '0;
         w_lane_ent[l] = i_nonpivot_fault_addr[w_lane_sel[l]*E_W +: E_W];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      np_cover_lane #(
         .ROW_W (ROW_W),
         .COL_W (COL_W),
         .PCAM  (PCAM)
      ) u_lane (
         .i_en         (w_lane_ent[l].en),
         .i_row        (w_lane_ent[l].row),
         .i_col        (w_lane_ent[l].col),
         .i_sp_row     (r_piv_row),
         .i_sp_row_vld (r_sp_row_vld),
         .i_sp_col     (r_piv_col),
         .i_sp_col_vld (r_sp_col_vld),
         .o_covered    (w_lane_cov[l])
      );
   end

   // Sum uncovered lanes of this beat and pick the lowest uncovered lane.
   always_comb begin
      w_unc_add    = '0;
      w_first_hit  = 1'b0;
      w_first_addr = '0;
      for (int l = 0; l < LANES; l++) begin
         if (w_lane_act[l] && !w_lane_cov[l]) begin
            w_unc_add = w_unc_add + CNT_W'(1);
            if (!w_first_hit) begin
               w_first_hit  = 1'b1;
               w_first_addr = {w_lane_ent[l].row, w_lane_ent[l].col};
            end
         end
      end
      w_cnt_next = r_unc_cnt + w_unc_add;
      w_limit    = (w_cnt_next >= CNT_W'(UNC_MAX));
      w_last     = ((r_idx + IDX_W'(LANES)) >= IDX_W'(NPCAM));
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and control strobes; abort overrides every transition.
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_latch_ok   = 1'b0;
      w_latch_fail = 1'b0;
      w_scan_upd   = 1'b0;
      o_busy       = (r_state != S_IDLE);
      o_done       = (r_state == S_DONE);
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LATCH;
            end
         end
         S_LATCH: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_overuse) begin
               w_latch_fail = 1'b1;
               w_state_nxt  = S_DONE;
            end else begin
               w_latch_ok  = 1'b1;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_scan_upd = 1'b1;
               if (w_limit || w_last) w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture, budget check and scan-result datapath.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_piv_en     <= '0;
         r_dsss       <= '0;
         r_piv_row    <= '0;
         r_piv_col    <= '0;
         r_sp_row_vld <= '0;
         r_sp_col_vld <= '0;
         r_idx        <= '0;
         r_status     <= ST_ALL_COVERED;
         r_rows_left  <= '0;
         r_cols_left  <= '0;
         r_unc_cnt    <= '0;
         r_cover      <= '0;
         r_first_vld  <= 1'b0;
         r_first_addr <= '0;
      end else begin
         if (w_accept) begin
            for (int k = 0; k < PCAM; k++) begin
               r_piv_en[k]  <= w_piv_ent[k].en;
               r_piv_row[k] <= w_piv_ent[k].row;
               r_piv_col[k] <= w_piv_ent[k].col;
            end
            r_dsss       <= i_dsss;
            r_idx        <= '0;
            r_unc_cnt    <= '0;
            r_cover      <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
         end
         if (w_latch_fail) begin
            r_status    <= ST_PIVOT_OVERUSE;
            r_rows_left <= '0;
            r_cols_left <= '0;
         end
         if (w_latch_ok) begin
            r_rows_left  <= RL_W'(NUM_RS - int'(w_rows_used));
            r_cols_left  <= CL_W'(NUM_CS - int'(w_cols_used));
            r_sp_row_vld <= r_piv_en & r_dsss;
            r_sp_col_vld <= r_piv_en & ~r_dsss;
         end
         if (w_scan_upd) begin
            for (int l = 0; l < LANES; l++) begin
               if (w_lane_act[l]) r_cover[w_lane_sel[l]] <= w_lane_cov[l];
            end
            r_unc_cnt <= w_cnt_next;
            r_idx     <= r_idx + IDX_W'(LANES);
            if (!r_first_vld && w_first_hit) begin
               r_first_vld  <= 1'b1;
               r_first_addr <= w_first_addr;
            end
            if (w_limit)
               r_status <= ST_UNC_LIMIT;
            else if (w_last)
               r_status <= (w_cnt_next == '0) ? ST_ALL_COVERED : ST_UNCOVERED;
         end
      end
   end

   assign o_status                = r_status;
   assign o_rows_left             = r_rows_left;
   assign o_cols_left             = r_cols_left;
   assign o_uncover_cnt           = r_unc_cnt;
   assign o_nonpivot_cover_result = r_cover;
   assign o_first_uncover_vld     = r_first_vld;
   assign o_first_uncover_addr    = r_first_addr;

endmodule
